// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared types and helpers for the bus-processor control unit
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101,
    OP_IL6  = 3'b110,
    OP_IL7  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ALU2 = 2'd2,
    ALU3 = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10
  } alu_op_t;

  // Opcodes that take the three-cycle A/G path through the ALU.
  function automatic logic is_alu(op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  // ALU control for the ALU2 cycle; non-ALU opcodes map to add.
  function automatic alu_op_t alu_code(op_t op);
    case (op)
      OP_SUB:  return SUB;
      OP_AND:  return AND;
      default: return ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// rtl/proc_ctrl_fsm_if.sv - controller/datapath signal bundle
interface proc_ctrl_fsm_if #(
  parameter int W    = 9,
  parameter int NREG = 8
);
  logic            run;
  logic [W-1:0]    DIN;
  logic            gnz;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            Gout;
  logic            DINout;
  logic            IRin;
  logic            Ain;
  logic            Gin;
  logic [1:0]      AluOp;
  logic            Done;
  logic            Illegal;

  modport master (
    input  run, DIN, gnz,
    output Rin, Rout, Gout, DINout, IRin, Ain, Gin, AluOp, Done, Illegal
  );

  modport slave (
    output run, DIN, gnz,
    input  Rin, Rout, Gout, DINout, IRin, Ain, Gin, AluOp, Done, Illegal
  );
endinterface

// File: rtl/reg_sel_decoder.sv
// rtl/reg_sel_decoder.sv - register-number to one-hot enable decoder
module reg_sel_decoder #(
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic [RW-1:0]   sel,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  // Single bit set at the selected register, nothing when disabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// rtl/proc_ctrl_fsm.sv - instruction register and bus sequencer for the bus processor
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int W    = 9,
  parameter int NREG = 8
) (
  input logic clk,
  input logic rst,
  proc_ctrl_fsm_if.master bus
);

  localparam int RW = $clog2(NREG);

  state_t        state_reg, state_next;
  logic [W-1:0]  ir;
  op_t           op;
  logic [RW-1:0] x, y;

  logic          ir_in;
  logic          rin_en, rout_en, rout_use_x;
  logic [RW-1:0] rout_sel;
  logic          ir_unused;

  assign op = op_t'(ir[W-1:W-3]);
  assign x  = ir[2*RW-1:RW];
  assign y  = ir[RW-1:0];
  // Middle IR bits between the opcode and X are don't-care.
  assign ir_unused = ^ir;

  // Rout normally follows Y; only the first ALU cycle reads X into A.
  assign rout_sel  = rout_use_x ? x : y;
  assign bus.IRin  = ir_in;

  reg_sel_decoder #(.NREG(NREG)) u_rin_dec (
    .sel    (x),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

  reg_sel_decoder #(.NREG(NREG)) u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Instruction register, captured in the run-accept cycle.
  always_ff @(posedge clk) begin
    if (rst)        ir <= '0;
    else if (ir_in) ir <= bus.DIN;
  end

  // Next-state: single-cycle opcodes return straight to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = bus.run ? EXEC : IDLE;
      EXEC:    state_next = is_alu(op) ? ALU2 : IDLE;
      ALU2:    state_next = ALU3;
      ALU3:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from state and IR; everything held low during reset.
  always_comb begin
    ir_in       = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_use_x  = 1'b0;
    bus.Gout    = 1'b0;
    bus.DINout  = 1'b0;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.AluOp   = ADD;
    bus.Done    = 1'b0;
    bus.Illegal = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: ir_in = bus.run;
        EXEC: begin
          case (op)
            OP_MV: begin
              rout_en  = 1'b1;
              rin_en   = 1'b1;
              bus.Done = 1'b1;
            end
            OP_MVI: begin
              bus.DINout = 1'b1;
              rin_en     = 1'b1;
              bus.Done   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              rout_en    = 1'b1;
              rout_use_x = 1'b1;
              bus.Ain    = 1'b1;
            end
            OP_MVNZ: begin
              rout_en  = bus.gnz;
              rin_en   = bus.gnz;
              bus.Done = 1'b1;
            end
            default: begin
              bus.Done    = 1'b1;
              bus.Illegal = 1'b1;
            end
          endcase
        end
        ALU2: begin
          rout_en   = 1'b1;
          bus.Gin   = 1'b1;
          bus.AluOp = alu_code(op);
        end
        ALU3: begin
          bus.Gout = 1'b1;
          rin_en   = 1'b1;
          bus.Done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb/tb_proc_ctrl_fsm.sv - scoreboard bench for proc_ctrl_fsm at 9/8 and 16/16
module tb_proc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_ctrl_fsm_if #(.W(9),  .NREG(8))  bus_a ();
  proc_ctrl_fsm_if #(.W(16), .NREG(16)) bus_b ();

  proc_ctrl_fsm #(.W(9), .NREG(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  proc_ctrl_fsm #(.W(16), .NREG(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        gout;
    logic        dinout;
    logic        irin;
    logic        ain;
    logic        gin;
    logic [1:0]  aluop;
    logic        done;
    logic        illegal;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } exp_t;

  exp_t sb [2][$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t get_outs(input int i);
    outs_t o;
    o = '0;
    if (i == 0) begin
      o.rin  = {8'b0, bus_a.Rin};
      o.rout = {8'b0, bus_a.Rout};
      o.gout = bus_a.Gout; o.dinout = bus_a.DINout; o.irin = bus_a.IRin;
      o.ain  = bus_a.Ain;  o.gin = bus_a.Gin; o.aluop = bus_a.AluOp;
      o.done = bus_a.Done; o.illegal = bus_a.Illegal;
    end else begin
      o.rin  = bus_b.Rin;
      o.rout = bus_b.Rout;
      o.gout = bus_b.Gout; o.dinout = bus_b.DINout; o.irin = bus_b.IRin;
      o.ain  = bus_b.Ain;  o.gin = bus_b.Gin; o.aluop = bus_b.AluOp;
      o.done = bus_b.Done; o.illegal = bus_b.Illegal;
    end
    return o;
  endfunction

  // Monitor: any cycle with activity must match the next scoreboard entry.
  task automatic mon(input int i, input outs_t act);
    exp_t e;
    if (act != '0) begin
      n_tests++;
      if (sb[i].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out[%0d] cyc=%0d got=%h required=idle", i, cyc, act);
      end else begin
        e = sb[i].pop_front();
        if (e.cyc != cyc || e.o != act) begin
          n_fail++;
          $display("FAIL out[%0d] cyc=%0d got=%h required=%h at cyc %0d", i, cyc, act, e.o, e.cyc);
        end
      end
    end else if (sb[i].size() > 0 && sb[i][0].cyc <= cyc) begin
      n_tests++;
      n_fail++;
      e = sb[i].pop_front();
      $display("FAIL missing_out[%0d] cyc=%0d got=idle required=%h at cyc %0d", i, cyc, e.o, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, get_outs(0));
    mon(1, get_outs(1));
  end

  // Reference: bus transfers each instruction performs, one entry per cycle.
  task automatic model_inst(input int i, input int c, input int op, input int x,
                            input int y, input logic g, input int lim);
    outs_t st[$];
    outs_t o;
    exp_t  e;
    o = '0; o.irin = 1'b1;
    e.cyc = c; e.o = o; sb[i].push_back(e);
    case (op)
      0: begin
        o = '0; o.rout = 16'd1 << y; o.rin = 16'd1 << x; o.done = 1'b1; st.push_back(o);
      end
      1: begin
        o = '0; o.dinout = 1'b1; o.rin = 16'd1 << x; o.done = 1'b1; st.push_back(o);
      end
      2, 3, 4: begin
        o = '0; o.rout = 16'd1 << x; o.ain = 1'b1; st.push_back(o);
        o = '0; o.rout = 16'd1 << y; o.gin = 1'b1;
        o.aluop = (op == 2) ? 2'b00 : (op == 3) ? 2'b01 : 2'b10;
        st.push_back(o);
        o = '0; o.gout = 1'b1; o.rin = 16'd1 << x; o.done = 1'b1; st.push_back(o);
      end
      5: begin
        o = '0; o.done = 1'b1;
        if (g) begin o.rout = 16'd1 << y; o.rin = 16'd1 << x; end
        st.push_back(o);
      end
      default: begin
        o = '0; o.done = 1'b1; o.illegal = 1'b1; st.push_back(o);
      end
    endcase
    for (int j = 0; j < st.size(); j++) begin
      if (1 + j < lim) begin
        e.cyc = c + 1 + j; e.o = st[j]; sb[i].push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic [15:0] din, input logic g);
    if (i == 0) begin
      bus_a.run = r; bus_a.DIN = din[8:0]; bus_a.gnz = g;
    end else begin
      bus_b.run = r; bus_b.DIN = din; bus_b.gnz = g;
    end
  endtask

  // Issue one instruction from IDLE; abort_at>0 asserts rst in that cycle offset.
  task automatic run_inst(input int i, input int op, input int x, input int y,
                          input int gsel, input int abort_at);
    int          c, len, ab;
    logic        g;
    logic [15:0] w;
    c   = cyc;
    len = (op >= 2 && op <= 4) ? 3 : 1;
    ab  = (abort_at > len) ? -1 : abort_at;
    g   = (gsel < 0) ? 1'($urandom) : 1'(gsel);
    if (i == 0) w = {7'b0, 3'(op), 3'(x), 3'(y)};
    else        w = {3'(op), 5'($urandom), 4'(x), 4'(y)};
    drive(i, 1'b1, w, 1'($urandom));
    model_inst(i, c, op, x, y, g, (ab < 0) ? 99 : ab);
    for (int k = 1; k <= len; k++) begin
      tick();
      drive(i, 1'($urandom), 16'($urandom), (k == 1) ? g : 1'($urandom));
      if (k == ab) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(i, 1'b0, 16'($urandom), 1'($urandom));
        return;
      end
    end
    tick();
    drive(i, 1'b0, 16'($urandom), 1'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, op, x, y, ab;
    outs_t a;
    rst = 1'b1;
    drive(0, 1'b1, 16'h01ff, 1'b1);
    drive(1, 1'b1, 16'hffff, 1'b1);
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        a = get_outs(k);
        n_tests++;
        if (a != '0) begin
          n_fail++;
          $display("FAIL reset_outs[%0d] got=%h required=0", k, a);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0);

    run_inst(0, 0, 3, 5, -1, -1);
    run_inst(0, 1, 2, 0, -1, -1);
    run_inst(0, 3, 1, 6, -1, -1);
    run_inst(0, 5, 4, 0, 0, -1);
    run_inst(0, 5, 4, 0, 1, -1);
    run_inst(0, 7, 2, 1, -1, -1);
    run_inst(0, 6, 5, 5, -1, -1);
    run_inst(0, 2, 3, 3, -1, 2);
    run_inst(0, 0, 7, 0, -1, -1);
    run_inst(1, 4, 15, 0, -1, -1);
    run_inst(1, 2, 9, 9, -1, -1);
    run_inst(1, 5, 0, 15, 1, -1);

    for (int n = 0; n < 160; n++) begin
      i  = $urandom_range(0, 1);
      op = $urandom_range(0, 7);
      x  = $urandom_range(0, (i == 0) ? 7 : 15);
      y  = $urandom_range(0, (i == 0) ? 7 : 15);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : -1;
      run_inst(i, op, x, y, -1, ab);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (sb[k].size() != 0) begin
        n_fail++;
        $display("FAIL drained[%0d] got=%0d pending required=0", k, sb[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Parametrised control unit for the simple bus-based processor. It holds the instruction register and sequences the shared-bus datapath for a configurable data width and register-file size. Compared with the 9-bit/8-register controller it adds AND, conditional move (MVNZ), a 2-bit ALU-op output, illegal-opcode reporting and clean run-gated fetch. It sits beside the datapath and drives every register enable, every bus-source select and the ALU controls.

## Interface
Parameters:
- W, 9, data/instruction width; must satisfy W ≥ 3 + 2·RW.
- NREG, 8, number of general registers (power of 2, ≥ 2); RW = $clog2(NREG).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- run  in  1  start request; sampled only in IDLE.
- DIN  in  W  instruction word / immediate from memory.
- gnz  in  1  datapath flag: G register ≠ 0.
- Rin  out  NREG  one-hot register write enables.
- Rout  out  NREG  one-hot register bus drives.
- Gout, DINout  out  1 each  bus-source selects for G and DIN.
- IRin, Ain, Gin  out  1 each  load enables for IR, A and G.
- AluOp  out  2  00 add, 01 sub, 10 and, 11 reserved.
- Done  out  1  one-cycle pulse at the last cycle of an instruction.
- Illegal  out  1  pulse together with Done for opcode 110 or 111.

## Operation
- IR fields: op = IR[W-1:W-3], X = IR[2RW-1:RW], Y = IR[RW-1:0]. Unused middle bits are ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 mvnz, 110/111 illegal.
- IR is internal and W bits wide. It loads DIN when IRin=1 and resets to 0.
- States: IDLE, EXEC, ALU2, ALU3.
- IDLE: IRin = run. If run=1, go to EXEC; otherwise stay.
- EXEC, by opcode:
  - mv: Rout[Y], Rin[X], Done; go to IDLE.
  - mvi: DINout, Rin[X], Done. DIN carries the immediate in this cycle. Go to IDLE.
  - add/sub/and: Rout[X], Ain; go to ALU2.
  - mvnz: if gnz=1, Rout[Y] and Rin[X]; otherwise no enables. Done in both cases. Go to IDLE.
  - illegal: Done and Illegal, no other enables; go to IDLE.
- ALU2: Rout[Y], Gin, AluOp per opcode; go to ALU3.
- ALU3: Gout, Rin[X], Done; go to IDLE.
- Outputs are combinational from state_reg and IR. Every output not listed for a state is 0.
- AluOp is 00 outside ALU2.
- X = Y is legal; the same register is read and written.
- run is ignored outside IDLE. Holding run high issues back-to-back instructions, each separated by one IDLE cycle.
- At most one bit of Rout, and at most one of {Rout, Gout, DINout}, is ever active in a cycle.

## Timing
- Latency counted from the run-accept edge in IDLE:
  - mv, mvi, mvnz, illegal: Done in the following cycle (2 cycles total).
  - add/sub/and: Done 3 cycles after accept (4 cycles total).
- Done and Illegal are exactly one cycle wide.
- Reset:
  - On any edge with rst=1, state_reg ← IDLE and IR ← 0, including mid-instruction. No Done is produced for the aborted instruction.
  - While rst=1, IRin is forced to 0 and all other outputs are 0.
  - The first instruction can be accepted on the first edge after rst falls.
- gnz is sampled combinationally in the EXEC cycle of mvnz.

## Structure
- Package proc_ctrl_pkg holds:
  - op_t enum (3-bit opcodes),
  - state_t enum (IDLE, EXEC, ALU2, ALU3),
  - alu_op_t constants (ADD=00, SUB=01, AND=10).
- Sub-module reg_sel_decoder #(NREG): RW-bit select plus enable in, NREG one-hot out. Instantiate it twice, once for X→Rin and once for Y→Rout.
- The IR register is inline in proc_ctrl_fsm.

## Test plan
- W=9, NREG=8. Reset, then run=1 with DIN=000_011_101 (mv R3,R5) → IRin in accept cycle; next cycle Rout=0010_0000, Rin=0000_1000, Done=1.
- mvi: DIN=001_010_000, then DIN=9'h0AB in the next cycle → that cycle has DINout=1, Rin[2]=1, Done=1.
- sub R1,R6 (011_001_110) → Ain+Rout[1]; then Gin+Rout[6] with AluOp=01; then Gout+Rin[1] with Done=1. Done appears 3 cycles after accept.
- mvnz R4,R0 (101_100_000): with gnz=0 → Done=1 and all enables 0; with gnz=1 → Rout[0]=1, Rin[4]=1, Done=1.
- Opcode 111 → Done=1 and Illegal=1, no enables. rst asserted in ALU2 of an add → next cycle IDLE, all outputs 0, no Done.
- W=16, NREG=16: and R15,R0 (op=100, X=1111, Y=0000) → AluOp=10 in ALU2; Rin[15]=1 with Done in ALU3.
